// File: rtl/fft_disp_pkg.sv
// Shared constants and write-side state encoding for the spectrum display buffer.
package fft_disp_pkg;

  localparam int N_POINTS_DEF = 128;
  localparam int DISP_W       = 8;

  typedef enum logic [1:0] {
    W_FILL = 2'd0,
    W_DROP = 2'd1,
    W_FULL = 2'd2
  } wr_state_e;

endpackage

// File: rtl/spectrum_dpram.sv
// Two-bank spectrum store: one write port, one read port with one cycle registered latency.
// No flow control; a write and a read to any address may occur every cycle.
module spectrum_dpram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_dat_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_dat_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
    rd_dat_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/fft_spectrum_buf.sv
// Ping-pong buffer between an FFT magnitude stream and an LCD spectrum display; fft_data lags fft_point_cnt by one cycle.
// fft_ready drops once a frame is complete and stays low until the next LCD frame_start swaps banks.
module fft_spectrum_buf
  import fft_disp_pkg::*;
#(
  parameter int N_POINTS = N_POINTS_DEF,
  parameter int MAG_W    = 16,
  parameter int SHIFT    = 8
) (
  input  logic             lcd_pclk,
  input  logic             rst_n,
  input  logic             fft_valid,
  input  logic             fft_last,
  input  logic [MAG_W-1:0] fft_mag,
  output logic             fft_ready,
  input  logic             frame_start,
  input  logic             data_req,
  input  logic             fft_point_done,
  output logic [7:0]       fft_point_cnt,
  output logic [7:0]       fft_data,
  output logic             buf_swapped
);

  localparam int IDX_W = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam int AW    = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  wr_state_e          state_q, state_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic               front_q, front_d;
  logic               valid_q, valid_d;
  logic               swap_q, swap_d;
  logic               rd_vld_q;
  logic               dreq_q;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               wr_en;
  logic [MAG_W-1:0]   shifted;
  logic [DISP_W-1:0]  wr_dat;
  logic [DISP_W-1:0]  rd_dat;

  assign fft_ready = rst_n && (state_q != W_FULL);
  assign accept    = fft_valid && fft_ready;

  assign shifted = fft_mag >> SHIFT;
  assign wr_dat  = (shifted > MAG_W'(255)) ? 8'hFF : shifted[DISP_W-1:0];

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    front_d  = front_q;
    valid_d  = valid_q;
    swap_d   = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      W_FILL: begin
        if (accept) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
          if (fft_last) begin
            state_d = W_FULL;
          end else if (wr_idx_q == LAST_IDX) begin
            state_d = W_DROP;
          end
        end
      end
      W_DROP: begin
        if (accept && fft_last) begin
          state_d = W_FULL;
        end
      end
      W_FULL: begin
        // Only a completed frame may be exposed to the display.
        if (frame_start) begin
          front_d  = ~front_q;
          wr_idx_d = '0;
          state_d  = W_FILL;
          swap_d   = 1'b1;
          valid_d  = 1'b1;
        end
      end
      default: state_d = W_FILL;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fft_point_done) begin
      cnt_d = '0;
    end else if (data_req && !dreq_q && (cnt_q != LAST_IDX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge lcd_pclk) begin
    if (!rst_n) begin
      state_q  <= W_FILL;
      wr_idx_q <= '0;
      front_q  <= 1'b0;
      valid_q  <= 1'b0;
      swap_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      dreq_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      front_q  <= front_d;
      valid_q  <= valid_d;
      swap_q   <= swap_d;
      rd_vld_q <= valid_q;
      dreq_q   <= data_req;
      cnt_q    <= cnt_d;
    end
  end

  spectrum_dpram #(
    .DEPTH (2 * N_POINTS),
    .AW    (AW),
    .DW    (DISP_W)
  ) u_ram (
    .clk_i     (lcd_pclk),
    .wr_en_i   (wr_en),
    .wr_addr_i ({~front_q, wr_idx_q}),
    .wr_dat_i  (wr_dat),
    .rd_addr_i ({front_q, cnt_q}),
    .rd_dat_o  (rd_dat)
  );

  // rd_vld_q trails valid_q so the read issued before the first swap is never shown.
  assign fft_data      = rd_vld_q ? rd_dat : 8'h00;
  assign fft_point_cnt = 8'(cnt_q);
  assign buf_swapped   = swap_q;

endmodule
